// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO result registers.
// Mult/div ops hold busy for a fixed cycle count and then commit HI/LO.
// MTHI/MTLO write HI/LO in a single cycle and never raise busy.
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

   localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES - 1);
   localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
   localparam logic [WIDTH-1:0] W_ZERO    = WIDTH'(0);
   localparam logic [WIDTH-1:0] W_ONE     = WIDTH'(1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Datapath works only from latched operands, so a/b may change after issue.
   logic [2*WIDTH-1:0] a_sx_s, b_sx_s, a_zx_s, b_zx_s;
   logic [2*WIDTH-1:0] prod_signed_s, prod_unsigned_s;
   logic               a_neg_s, b_neg_s, div_zero_s;
   logic [WIDTH-1:0]   a_mag_s, b_mag_s, b_div_s;
   logic [WIDTH-1:0]   quo_mag_s, rem_mag_s, quo_s, rem_s;

   assign a_sx_s          = {{WIDTH{a_q[WIDTH-1]}}, a_q};
   assign b_sx_s          = {{WIDTH{b_q[WIDTH-1]}}, b_q};
   assign a_zx_s          = {W_ZERO, a_q};
   assign b_zx_s          = {W_ZERO, b_q};
   assign prod_signed_s   = a_sx_s * b_sx_s;
   assign prod_unsigned_s = a_zx_s * b_zx_s;

   // Signed divide is done on magnitudes; the most-negative / -1 case
   // naturally yields quotient == dividend and remainder 0.
   assign a_neg_s    = (op_q == OP_DIV) & a_q[WIDTH-1];
   assign b_neg_s    = (op_q == OP_DIV) & b_q[WIDTH-1];
   assign a_mag_s    = a_neg_s ? (~a_q + W_ONE) : a_q;
   assign b_mag_s    = b_neg_s ? (~b_q + W_ONE) : b_q;
   assign div_zero_s = (b_q == W_ZERO);
   assign b_div_s    = div_zero_s ? W_ONE : b_mag_s;
   assign quo_mag_s  = a_mag_s / b_div_s;
   assign rem_mag_s  = a_mag_s % b_div_s;
   assign quo_s      = (a_neg_s ^ b_neg_s) ? (~quo_mag_s + W_ONE) : quo_mag_s;
   assign rem_s      = a_neg_s ? (~rem_mag_s + W_ONE) : rem_mag_s;

   // State register: async reset clears everything, aborting any op in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_ZERO;
         op_q    <= 3'd0;
         a_q     <= W_ZERO;
         b_q     <= W_ZERO;
         hi_q    <= W_ZERO;
         lo_q    <= W_ZERO;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state: issue/MT writes in IDLE, countdown and commit in RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     op_d    = op;
                     a_d     = a;
                     b_d     = b;
                     cnt_d   = MULT_LOAD;
                     busy_d  = 1'b1;
                     state_d = S_RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     op_d    = op;
                     a_d     = a;
                     b_d     = b;
                     cnt_d   = DIV_LOAD;
                     busy_d  = 1'b1;
                     state_d = S_RUN;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: state_d = S_IDLE;
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (cnt_q == CNT_ZERO) begin
               case (op_q)
                  OP_MULT:  {hi_d, lo_d} = prod_signed_s;
                  OP_MULTU: {hi_d, lo_d} = prod_unsigned_s;
                  OP_DIV, OP_DIVU: begin
                     // Divide by zero keeps HI/LO untouched.
                     if (!div_zero_s) begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                     end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                     end
                  end
                  default: begin
                     hi_d = hi_q;
                     lo_d = lo_q;
                  end
               endcase
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
